// File: rtl/xmpl_sram_pkg.sv
// Shared types for the SRAM arbiter slice: request fields and read-return tags.
// No logic, so there is no latency and no backpressure.
package xmpl_sram_pkg;

   localparam int ADDR_W  = 12;
   localparam int DATA_W  = 32;
   localparam int MAX_REQ = 8;
   localparam int ID_W    = $clog2(MAX_REQ);

   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } sram_req_t;

   // The id is sized for the largest supported requester count.
   typedef struct packed {
      logic            vld;
      logic [ID_W-1:0] id;
   } rsp_tag_t;

endpackage

// File: rtl/xmpl_rr_arb.sv
// Round-robin picker: the scan starts at ptr and wraps; the first request found wins.
// Grant is combinational (0 cycles); ptr moves past the winner only when adv is set.
module xmpl_rr_arb #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [N-1:0]  req,
   input  logic          adv,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx
);

   logic [IW-1:0] ptr_q;
   logic [IW-1:0] pos;
   logic          found;

   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      pos   = '0;
      for (int k = 0; k < N; k++) begin
         pos = IW'((int'(ptr_q) + k) % N);
         if (!found && req[pos]) begin
            found    = 1'b1;
            gnt[pos] = 1'b1;
            idx      = pos;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q <= '0;
      end else if (adv && found) begin
         ptr_q <= (idx == IW'(N - 1)) ? '0 : idx + 1'b1;
      end
   end

endmodule

// File: rtl/xmpl_sram_arb.sv
// Shares one single-port SRAM between NUM_REQ requesters. Grants are round-robin and SRAM controls are registered.
// A read returns RD_LAT+2 cycles after its handshake. Responses cannot be backpressured; a request waits only for its grant.
module xmpl_sram_arb #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 12,
   parameter int DATA_W  = 32,
   parameter int RD_LAT  = 1
) (
   input  logic                      clk_i,
   input  logic                      reset_i,
   input  logic [NUM_REQ-1:0]        req_valid_i,
   output logic [NUM_REQ-1:0]        req_ready_o,
   input  logic [NUM_REQ-1:0]        req_we_i,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
   output logic [NUM_REQ-1:0]        rsp_valid_o,
   output logic [DATA_W-1:0]         rsp_rdata_o,
   output logic                      en_sram_o,
   output logic [ADDR_W-1:0]         sram_addr_o,
   output logic                      sram_rw_o,
   output logic [DATA_W-1:0]         sram_data_o,
   input  logic [DATA_W-1:0]         sram_data_i
);

   import xmpl_sram_pkg::*;

   localparam int IDX_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0] gnt;
   logic [IDX_W-1:0]   gnt_idx;
   logic               hs;
   sram_req_t          win;
   sram_req_t          sram_q;
   logic               en_q;
   rsp_tag_t           tag_q [RD_LAT+1];
   logic [NUM_REQ-1:0] rsp_vld_q;
   logic [DATA_W-1:0]  rsp_dat_q;

   logic [ADDR_W-1:0] addr_a  [NUM_REQ];
   logic [DATA_W-1:0] wdata_a [NUM_REQ];

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign addr_a[i]  = req_addr_i[i*ADDR_W +: ADDR_W];
      assign wdata_a[i] = req_wdata_i[i*DATA_W +: DATA_W];
   end

   xmpl_rr_arb #(.N(NUM_REQ), .IW(IDX_W)) u_arb (
      .clk (clk_i),
      .rst (reset_i),
      .req (req_valid_i),
      .adv (hs),
      .gnt (gnt),
      .idx (gnt_idx)
   );

   // The grant is raised only for a valid requester, so any grant is a handshake.
   assign req_ready_o = gnt;
   assign hs          = |gnt;

   always_comb begin
      win.we    = req_we_i[gnt_idx];
      win.addr  = addr_a[gnt_idx];
      win.wdata = wdata_a[gnt_idx];
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         en_q   <= 1'b0;
         sram_q <= '0;
      end else begin
         en_q <= hs;
         if (hs) begin
            sram_q <= win;
         end
      end
   end

   assign en_sram_o   = en_q;
   assign sram_addr_o = sram_q.addr;
   assign sram_rw_o   = sram_q.we;
   assign sram_data_o = sram_q.wdata;

   // Stage 0 lines up with en_sram_o, and stage RD_LAT lines up with valid sram_data_i.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         for (int k = 0; k <= RD_LAT; k++) begin
            tag_q[k] <= '0;
         end
      end else begin
         tag_q[0].vld <= hs && !win.we;
         tag_q[0].id  <= ID_W'(gnt_idx);
         for (int k = 1; k <= RD_LAT; k++) begin
            tag_q[k] <= tag_q[k-1];
         end
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         rsp_vld_q <= '0;
         rsp_dat_q <= '0;
      end else if (tag_q[RD_LAT].vld) begin
         rsp_vld_q <= {{(NUM_REQ-1){1'b0}}, 1'b1} << tag_q[RD_LAT].id;
         rsp_dat_q <= sram_data_i;
      end else begin
         rsp_vld_q <= '0;
      end
   end

   assign rsp_valid_o = rsp_vld_q;
   assign rsp_rdata_o = rsp_dat_q;

endmodule

// File: tb/tb_xmpl_sram_arb.sv
// Directed bench for xmpl_sram_arb. It runs two instances on the same stimulus, one built with RD_LAT=1 and one with RD_LAT=3.
// Each instance gets its own behavioural SRAM read pipeline, and both share one memory array.
module tb_xmpl_sram_arb;

   localparam int NR = 4;
   localparam int AW = 12;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [NR-1:0]    req_valid;
   logic [NR-1:0]    req_we;
   logic [NR*AW-1:0] req_addr;
   logic [NR*DW-1:0] req_wdata;

   logic [NR-1:0] rdy0, rv0, rdy3, rv3;
   logic [DW-1:0] rd_o0, sd0, si0, rd_o3, sd3, si3;
   logic [AW-1:0] sa0, sa3;
   logic          en0, rw0, en3, rw3;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   xmpl_sram_arb #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) u0 (
      .clk_i(clk), .reset_i(rst), .req_valid_i(req_valid), .req_ready_o(rdy0),
      .req_we_i(req_we), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
      .rsp_valid_o(rv0), .rsp_rdata_o(rd_o0), .en_sram_o(en0), .sram_addr_o(sa0),
      .sram_rw_o(rw0), .sram_data_o(sd0), .sram_data_i(si0)
   );

   xmpl_sram_arb #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(3)) u3 (
      .clk_i(clk), .reset_i(rst), .req_valid_i(req_valid), .req_ready_o(rdy3),
      .req_we_i(req_we), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
      .rsp_valid_o(rv3), .rsp_rdata_o(rd_o3), .en_sram_o(en3), .sram_addr_o(sa3),
      .sram_rw_o(rw3), .sram_data_o(sd3), .sram_data_i(si3)
   );

   // Both instances issue the same command stream, so writes from u0 alone keep the shared array correct.
   bit   [DW-1:0] mem [0:4095];
   logic [DW-1:0] p3 [0:2];

   always @(posedge clk) begin
      if (en0 && rw0) mem[sa0] <= sd0;
      if (en0 && !rw0) si0 <= mem[sa0];
      if (en3 && !rw3) p3[0] <= mem[sa3];
      p3[1] <= p3[0];
      p3[2] <= p3[1];
   end
   assign si3 = p3[2];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (cyc > 20000) begin
         $display("FAIL watchdog: cycle %0d reached, limit 20000", cyc);
         $fatal(1, "bench did not terminate");
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic v, input logic we,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_valid[i]          = v;
      req_we[i]             = we;
      req_addr[i*AW +: AW]  = a;
      req_wdata[i*DW +: DW] = d;
   endtask

   task automatic test_reset();
      rst = 1'b1; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
      repeat (2) @(posedge clk);
      #1;
      n_tests++; if (en0 !== 1'b0) begin n_fail++; $display("FAIL rst_en: got %b want 0", en0); end
      n_tests++; if ({sa0, rw0, sd0} !== '0) begin n_fail++; $display("FAIL rst_sram: addr %h rw %b data %h want 0", sa0, rw0, sd0); end
      n_tests++; if ({rv0, rd_o0, rv3} !== '0) begin n_fail++; $display("FAIL rst_rsp: vld %b data %h vld3 %b want 0", rv0, rd_o0, rv3); end
      n_tests++; if (rdy0 !== 4'b0000) begin n_fail++; $display("FAIL rst_rdy: got %b want 0000", rdy0); end
      rst = 1'b0;
      tick();
      set_req(2, 1'b1, 1'b0, 12'h010, 32'h0);
      @(negedge clk);
      n_tests++; if (rdy0 !== 4'b0100) begin n_fail++; $display("FAIL midrd_rdy: got %b want 0100", rdy0); end
      tick();
      req_valid = '0;
      n_tests++; if (en0 !== 1'b1) begin n_fail++; $display("FAIL midrd_en: got %b want 1", en0); end
      rst = 1'b1;
      #1;
      n_tests++; if ({en0, sa0, rv0} !== '0) begin n_fail++; $display("FAIL midrd_async: en %b addr %h vld %b want 0", en0, sa0, rv0); end
      tick();
      rst = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         n_tests++; if (rv0 !== 4'b0 || rv3 !== 4'b0) begin n_fail++; $display("FAIL midrd_norsp c%0d: vld %b vld3 %b want 0000", c, rv0, rv3); end
         tick();
      end
   endtask

   task automatic test_single_wr_rd();
      repeat (6) tick();
      set_req(0, 1'b1, 1'b1, 12'h123, 32'hDEADBEEF);
      @(negedge clk);
      n_tests++; if (rdy0 !== 4'b0001) begin n_fail++; $display("FAIL wr_rdy: got %b want 0001", rdy0); end
      tick();
      n_tests++; if ({en0, rw0, sa0, sd0} !== {1'b1, 1'b1, 12'h123, 32'hDEADBEEF}) begin n_fail++; $display("FAIL wr_issue: en %b rw %b addr %h data %h want 1 1 123 deadbeef", en0, rw0, sa0, sd0); end
      set_req(0, 1'b1, 1'b0, 12'h123, 32'h0);
      @(negedge clk);
      n_tests++; if (rdy0 !== 4'b0001) begin n_fail++; $display("FAIL rd_rdy: got %b want 0001", rdy0); end
      tick();
      req_valid = '0;
      n_tests++; if ({en0, rw0, sa0} !== {1'b1, 1'b0, 12'h123}) begin n_fail++; $display("FAIL rd_issue: en %b rw %b addr %h want 1 0 123", en0, rw0, sa0); end
      tick();
      n_tests++; if ({en0, sa0, rv0} !== {1'b0, 12'h123, 4'b0}) begin n_fail++; $display("FAIL rd_idle: en %b addr %h vld %b want 0 123 0000", en0, sa0, rv0); end
      tick();
      n_tests++; if (rv0 !== 4'b0001 || rd_o0 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_rsp: vld %b data %h want 0001 deadbeef", rv0, rd_o0); end
      tick();
      n_tests++; if (rv0 !== 4'b0 || rd_o0 !== 32'hDEADBEEF || rv3 !== 4'b0) begin n_fail++; $display("FAIL rd_hold: vld %b data %h vld3 %b want 0000 deadbeef 0000", rv0, rd_o0, rv3); end
      tick();
      n_tests++; if (rv3 !== 4'b0001 || rd_o3 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_rsp_lat3: vld %b data %h want 0001 deadbeef", rv3, rd_o3); end
   endtask

   task automatic test_round_robin();
      repeat (6) tick();
      for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b1, 12'h200 + 12'(i), 32'hC0DE0000 + 32'(i));
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         n_tests++; if (rdy0 !== 4'b1 << ((1 + c) % 4)) begin n_fail++; $display("FAIL rr_wr c%0d: got %b want %b", c, rdy0, 4'b1 << ((1 + c) % 4)); end
         tick();
         req_valid[(1 + c) % 4] = 1'b0;
      end
      set_req(3, 1'b1, 1'b1, 12'h300, 32'h33333333);
      @(negedge clk);
      n_tests++; if (rdy0 !== 4'b1000) begin n_fail++; $display("FAIL rr_wr3: got %b want 1000", rdy0); end
      tick();
      for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b0, 12'h200 + 12'(i), 32'h0);
      for (int c = 0; c < 11; c++) begin
         @(negedge clk);
         if (c < 8) begin
            n_tests++; if (rdy0 !== 4'b1 << (c % 4)) begin n_fail++; $display("FAIL rr_rd_gnt c%0d: got %b want %b", c, rdy0, 4'b1 << (c % 4)); end
         end
         if (c >= 3) begin
            n_tests++; if (rv0 !== 4'b1 << ((c - 3) % 4) || rd_o0 !== 32'hC0DE0000 + 32'((c - 3) % 4)) begin n_fail++; $display("FAIL rr_rsp c%0d: vld %b data %h want %b %h", c, rv0, rd_o0, 4'b1 << ((c - 3) % 4), 32'hC0DE0000 + 32'((c - 3) % 4)); end
         end else begin
            n_tests++; if (rv0 !== 4'b0) begin n_fail++; $display("FAIL rr_rsp_early c%0d: vld %b want 0000", c, rv0); end
         end
         tick();
         if (c == 7) req_valid = '0;
      end
   endtask

   task automatic test_ptr_wrap();
      repeat (6) tick();
      set_req(1, 1'b1, 1'b1, 12'h400, 32'h11110000);
      @(negedge clk);
      n_tests++; if (rdy0 !== 4'b0010) begin n_fail++; $display("FAIL ptr_setup: got %b want 0010", rdy0); end
      tick();
      req_valid = '0;
      set_req(1, 1'b1, 1'b0, 12'h201, 32'h0);
      set_req(3, 1'b1, 1'b0, 12'h203, 32'h0);
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (c == 0) begin
            n_tests++; if (rdy0 !== 4'b1000) begin n_fail++; $display("FAIL ptr_first: got %b want 1000", rdy0); end
         end
         if (c == 1) begin
            n_tests++; if (rdy0 !== 4'b0010) begin n_fail++; $display("FAIL ptr_second: got %b want 0010", rdy0); end
         end
         if (c == 3) begin
            n_tests++; if (rv0 !== 4'b1000 || rd_o0 !== 32'hC0DE0003) begin n_fail++; $display("FAIL ptr_rsp3: vld %b data %h want 1000 c0de0003", rv0, rd_o0); end
         end
         if (c == 4) begin
            n_tests++; if (rv0 !== 4'b0010 || rd_o0 !== 32'hC0DE0001) begin n_fail++; $display("FAIL ptr_rsp1: vld %b data %h want 0010 c0de0001", rv0, rd_o0); end
         end
         if (c == 2 || c == 5) begin
            n_tests++; if (rv0 !== 4'b0) begin n_fail++; $display("FAIL ptr_rsp_gap c%0d: vld %b want 0000", c, rv0); end
         end
         tick();
         if (c == 0) req_valid[3] = 1'b0;
         if (c == 1) req_valid[1] = 1'b0;
      end
      req_valid = 4'b1111;
      @(negedge clk);
      n_tests++; if (rdy0 !== 4'b0100) begin n_fail++; $display("FAIL ptr_end: got %b want 0100", rdy0); end
      req_valid = '0;
   endtask

   task automatic test_raw();
      repeat (6) tick();
      set_req(1, 1'b1, 1'b1, 12'h7FF, 32'h5A5A1234);
      @(negedge clk);
      n_tests++; if (rdy0 !== 4'b0010) begin n_fail++; $display("FAIL raw_wr_rdy: got %b want 0010", rdy0); end
      tick();
      req_valid[1] = 1'b0;
      set_req(2, 1'b1, 1'b0, 12'h7FF, 32'h0);
      n_tests++; if ({en0, rw0, sa0} !== {1'b1, 1'b1, 12'h7FF} || {rw3, sd3} !== {1'b1, 32'h5A5A1234}) begin n_fail++; $display("FAIL raw_wr_issue: en %b rw %b addr %h rw3 %b data3 %h want 1 1 7ff 1 5a5a1234", en0, rw0, sa0, rw3, sd3); end
      @(negedge clk);
      n_tests++; if (rdy0 !== 4'b0100 || rdy3 !== 4'b0100) begin n_fail++; $display("FAIL raw_rd_rdy: got %b rdy3 %b want 0100", rdy0, rdy3); end
      tick();
      req_valid = '0;
      n_tests++; if ({en0, rw0, sa0} !== {1'b1, 1'b0, 12'h7FF}) begin n_fail++; $display("FAIL raw_rd_issue: en %b rw %b addr %h want 1 0 7ff", en0, rw0, sa0); end
      repeat (2) tick();
      n_tests++; if (rv0 !== 4'b0100 || rd_o0 !== 32'h5A5A1234) begin n_fail++; $display("FAIL raw_rsp: vld %b data %h want 0100 5a5a1234", rv0, rd_o0); end
      repeat (2) tick();
      n_tests++; if (rv3 !== 4'b0100 || rd_o3 !== 32'h5A5A1234) begin n_fail++; $display("FAIL raw_rsp_lat3: vld %b data %h want 0100 5a5a1234", rv3, rd_o3); end
   endtask

   task automatic test_back_to_back_lat3();
      repeat (6) tick();
      set_req(0, 1'b1, 1'b0, 12'h200, 32'h0);
      for (int c = 0; c < 9; c++) begin
         @(negedge clk);
         if (c < 3) begin
            n_tests++; if (rdy0 !== 4'b0001) begin n_fail++; $display("FAIL b2b_rdy c%0d: got %b want 0001", c, rdy0); end
         end
         if (c >= 5 && c <= 7) begin
            n_tests++; if (rv3 !== 4'b0001 || rd_o3 !== 32'hC0DE0000 + 32'(c - 5)) begin n_fail++; $display("FAIL b2b_lat3 c%0d: vld %b data %h want 0001 %h", c, rv3, rd_o3, 32'hC0DE0000 + 32'(c - 5)); end
         end else begin
            n_tests++; if (rv3 !== 4'b0) begin n_fail++; $display("FAIL b2b_lat3_idle c%0d: vld %b want 0000", c, rv3); end
         end
         if (c >= 3 && c <= 5) begin
            n_tests++; if (rv0 !== 4'b0001 || rd_o0 !== 32'hC0DE0000 + 32'(c - 3)) begin n_fail++; $display("FAIL b2b_lat1 c%0d: vld %b data %h want 0001 %h", c, rv0, rd_o0, 32'hC0DE0000 + 32'(c - 3)); end
         end
         tick();
         if (c < 2) req_addr[0 +: AW] = 12'h201 + 12'(c);
         if (c == 2) req_valid = '0;
      end
   endtask

   initial begin
      test_reset();
      test_single_wr_rd();
      test_round_robin();
      test_ptr_wrap();
      test_raw();
      test_back_to_back_lat3();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
